interrupt_sequencer: RTL and testbench

//  Sequences the datapath through the 7-cycle interrupt entry: dummy cycle, push PCH, push PCL,

---
 rtl/interrupt_sequencer_if.sv | 26 ++
 rtl/interrupt_sequencer.sv | 155 +++++++++++++++
 tb/tb_interrupt_sequencer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/interrupt_sequencer_if.sv
// Decoder/pin side of the interrupt sequencer: request inputs and the step-strobe outputs.
// The master drives requests and observes strobes; the sequencer is the slave.
interface interrupt_sequencer_if;
  logic       nmi_n;
  logic       irq_n;
  logic       i_flag;
  logic       instr_boundary;
  logic       brk_req;
  logic       seq_active;
  logic [5:0] step;
  logic       push_en;
  logic       brk_bit;
  logic [1:0] vec_sel;
  logic       set_i;
  logic       seq_done;

  modport master (
    output nmi_n, irq_n, i_flag, instr_boundary, brk_req,
    input  seq_active, step, push_en, brk_bit, vec_sel, set_i, seq_done
  );

  modport slave (
    input  nmi_n, irq_n, i_flag, instr_boundary, brk_req,
    output seq_active, step, push_en, brk_bit, vec_sel, set_i, seq_done
  );
endinterface

// File: rtl/interrupt_sequencer.sv
// Seven-cycle interrupt entry sequencer for RESET/NMI/BRK/IRQ: arbitration, NMI edge latch,
// late NMI hijack of IRQ/BRK vectors, and registered one-hot step strobes for the decoder.
module interrupt_sequencer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  interrupt_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_DONE
  } state_e;

  typedef enum logic [1:0] {
    K_RESET, K_NMI, K_BRK, K_IRQ
  } kind_e;

  state_e                 state_q, state_d;
  kind_e                  kind_q, kind_d;
  logic                   rst_pend_q, rst_pend_d;
  logic                   nmi_pend_q, nmi_pend_d;
  logic [SYNC_STAGES-1:0] nmi_sync_q, nmi_sync_d;
  logic [SYNC_STAGES-1:0] irq_sync_q, irq_sync_d;
  logic                   nmi_prev_q, nmi_prev_d;

  logic                   seq_active_q, seq_active_d;
  logic [5:0]             step_q, step_d;
  logic                   push_en_q, push_en_d;
  logic                   brk_bit_q, brk_bit_d;
  logic [1:0]             vec_sel_q, vec_sel_d;
  logic                   set_i_q, set_i_d;
  logic                   seq_done_q, seq_done_d;

  logic nmi_s, irq_s, nmi_fall, irq_req, nmi_clear;

  always_comb begin
    nmi_sync_d    = nmi_sync_q;
    irq_sync_d    = irq_sync_q;
    nmi_sync_d[0] = bus.nmi_n;
    irq_sync_d[0] = bus.irq_n;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      nmi_sync_d[i] = nmi_sync_q[i-1];
      irq_sync_d[i] = irq_sync_q[i-1];
    end

    nmi_s      = nmi_sync_q[SYNC_STAGES-1];
    irq_s      = irq_sync_q[SYNC_STAGES-1];
    nmi_prev_d = nmi_s;
    nmi_fall   = nmi_prev_q & ~nmi_s;
    irq_req    = ~irq_s & ~bus.i_flag;

    // A fresh edge in the same T5 that retires an NMI must not be lost: set wins.
    nmi_clear  = (state_q == S_T5) && (kind_q == K_NMI);
    nmi_pend_d = nmi_fall | (nmi_pend_q & ~nmi_clear);

    state_d    = state_q;
    kind_d     = kind_q;
    rst_pend_d = rst_pend_q;

    case (state_q)
      S_IDLE: begin
        if (rst_pend_q) begin
          state_d    = S_T1;
          kind_d     = K_RESET;
          rst_pend_d = 1'b0;
        end else if (bus.instr_boundary && (nmi_pend_q || bus.brk_req || irq_req)) begin
          state_d = S_T1;
          if (nmi_pend_q)       kind_d = K_NMI;
          else if (bus.brk_req) kind_d = K_BRK;
          else                  kind_d = K_IRQ;
        end
      end
      S_T1: state_d = S_T2;
      S_T2: state_d = S_T3;
      S_T3: state_d = S_T4;
      S_T4: begin
        state_d = S_T5;
        // An NMI that arrived before the vector fetch steals the IRQ/BRK entry.
        if (nmi_pend_q && (kind_q == K_BRK || kind_q == K_IRQ)) kind_d = K_NMI;
      end
      S_T5:    state_d = S_T6;
      S_T6:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    seq_active_d = (state_d != S_IDLE) && (state_d != S_DONE);
    step_d       = 6'b000000;
    case (state_d)
      S_T1:    step_d = 6'b000001;
      S_T2:    step_d = 6'b000010;
      S_T3:    step_d = 6'b000100;
      S_T4:    step_d = 6'b001000;
      S_T5:    step_d = 6'b010000;
      S_T6:    step_d = 6'b100000;
      default: step_d = 6'b000000;
    endcase
    push_en_d = (state_d inside {S_T2, S_T3, S_T4}) && (kind_d != K_RESET);
    brk_bit_d = (state_d == S_T4) && (kind_d == K_BRK);
    vec_sel_d = 2'b00;
    if (state_d inside {S_T5, S_T6}) begin
      case (kind_d)
        K_NMI:   vec_sel_d = 2'b10;
        K_RESET: vec_sel_d = 2'b01;
        default: vec_sel_d = 2'b00;
      endcase
    end
    set_i_d    = (state_d == S_T5);
    seq_done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      kind_q       <= K_RESET;
      rst_pend_q   <= 1'b1;
      nmi_pend_q   <= 1'b0;
      nmi_sync_q   <= '0;
      irq_sync_q   <= '0;
      nmi_prev_q   <= 1'b0;
      seq_active_q <= 1'b0;
      step_q       <= 6'b000000;
      push_en_q    <= 1'b0;
      brk_bit_q    <= 1'b0;
      vec_sel_q    <= 2'b00;
      set_i_q      <= 1'b0;
      seq_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      kind_q       <= kind_d;
      rst_pend_q   <= rst_pend_d;
      nmi_pend_q   <= nmi_pend_d;
      nmi_sync_q   <= nmi_sync_d;
      irq_sync_q   <= irq_sync_d;
      nmi_prev_q   <= nmi_prev_d;
      seq_active_q <= seq_active_d;
      step_q       <= step_d;
      push_en_q    <= push_en_d;
      brk_bit_q    <= brk_bit_d;
      vec_sel_q    <= vec_sel_d;
      set_i_q      <= set_i_d;
      seq_done_q   <= seq_done_d;
    end
  end

  assign bus.seq_active = seq_active_q;
  assign bus.step       = step_q;
  assign bus.push_en    = push_en_q;
  assign bus.brk_bit    = brk_bit_q;
  assign bus.vec_sel    = vec_sel_q;
  assign bus.set_i      = set_i_q;
  assign bus.seq_done   = seq_done_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Bench for interrupt_sequencer: directed scenarios followed by random traffic, every cycle
// compared against a cycle-position reference model of the interrupt entry sequence.
module tb_interrupt_sequencer;
  localparam int SYNC    = 2;
  localparam int K_RESET = 0;
  localparam int K_NMI   = 1;
  localparam int K_BRK   = 2;
  localparam int K_IRQ   = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  interrupt_sequencer_if bus();

  interrupt_sequencer #(.SYNC_STAGES(SYNC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: position in sequence (0 idle, 1..6 = T1..T6, 7 done) plus kind;
  // synchronizers modelled as the pin value delayed by SYNC edges (index 0 = newest).
  int m_pos;
  int m_kind;
  bit m_rst_pend;
  bit m_nmi_pend;
  bit nmi_hist [SYNC+1];
  bit irq_hist [SYNC+1];

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int cyc    = 0;
  int t1_cnt = 0;

  task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic modelStep();
    bit fall, irq_ok, clr, pend;
    if (rst) begin
      m_pos      = 0;
      m_kind     = K_RESET;
      m_rst_pend = 1'b1;
      m_nmi_pend = 1'b0;
      for (int i = 0; i <= SYNC; i++) begin
        nmi_hist[i] = 1'b0;
        irq_hist[i] = 1'b0;
      end
    end else begin
      fall   = nmi_hist[SYNC] && !nmi_hist[SYNC-1];
      irq_ok = !irq_hist[SYNC-1] && !bus.i_flag;
      clr    = (m_pos == 5) && (m_kind == K_NMI);
      pend   = m_nmi_pend;
      if (m_pos == 0) begin
        if (m_rst_pend) begin
          m_pos      = 1;
          m_kind     = K_RESET;
          m_rst_pend = 1'b0;
        end else if (bus.instr_boundary && (pend || bus.brk_req || irq_ok)) begin
          m_pos  = 1;
          m_kind = pend ? K_NMI : (bus.brk_req ? K_BRK : K_IRQ);
        end
      end else if (m_pos == 7) begin
        m_pos = 0;
      end else begin
        if (m_pos == 4 && pend && (m_kind == K_BRK || m_kind == K_IRQ)) m_kind = K_NMI;
        m_pos = m_pos + 1;
      end
      m_nmi_pend = fall || (pend && !clr);
      for (int i = SYNC; i > 0; i--) begin
        nmi_hist[i] = nmi_hist[i-1];
        irq_hist[i] = irq_hist[i-1];
      end
      nmi_hist[0] = bus.nmi_n;
      irq_hist[0] = bus.irq_n;
    end
  endtask

  task automatic checkOutput();
    bit in_seq;
    int exp_step, exp_vec;
    in_seq   = (m_pos >= 1) && (m_pos <= 6);
    exp_step = in_seq ? (1 << (m_pos - 1)) : 0;
    exp_vec  = 0;
    if (m_pos == 5 || m_pos == 6) exp_vec = (m_kind == K_NMI) ? 2 : ((m_kind == K_RESET) ? 1 : 0);
    checkOne("seq_active", 32'(bus.seq_active), 32'(in_seq));
    checkOne("step",       32'(bus.step),       32'(exp_step));
    checkOne("push_en",    32'(bus.push_en),    32'(m_pos >= 2 && m_pos <= 4 && m_kind != K_RESET));
    checkOne("brk_bit",    32'(bus.brk_bit),    32'(m_pos == 4 && m_kind == K_BRK));
    checkOne("vec_sel",    32'(bus.vec_sel),    32'(exp_vec));
    checkOne("set_i",      32'(bus.set_i),      32'(m_pos == 5));
    checkOne("seq_done",   32'(bus.seq_done),   32'(m_pos == 7));
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk);
    #1;
    cyc++;
    checkOutput();
    if (bus.step[0] === 1'b1) t1_cnt++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic applyStimulus(input bit r, input bit nmi, input bit irq, input bit iflag,
                               input bit ib, input bit brk);
    rst                = r;
    bus.nmi_n          = nmi;
    bus.irq_n          = irq;
    bus.i_flag         = iflag;
    bus.instr_boundary = ib;
    bus.brk_req        = brk;
  endtask

  initial begin
    int start, done_at, act_cnt, first_t1, second_t1, guard;
    bit nmi_v, irq_v;

    m_pos = 0; m_kind = K_RESET; m_rst_pend = 1'b1; m_nmi_pend = 1'b0;
    for (int i = 0; i <= SYNC; i++) begin
      nmi_hist[i] = 1'b0;
      irq_hist[i] = 1'b0;
    end

    // 1) Reset sequence: vector FC, no pushes, done seven cycles after release.
    $display("[TB] reset sequence");
    applyStimulus(1, 1, 1, 1, 0, 0);
    ticks(3);
    applyStimulus(0, 1, 1, 1, 0, 0);
    start   = cyc;
    done_at = -1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.seq_done === 1'b1 && done_at < 0) done_at = cyc - start;
    end
    checkOne("reset_done_latency", 32'(done_at), 32'd7);

    // 2) IRQ unmasked, then masked.
    $display("[TB] irq sequence");
    applyStimulus(0, 1, 0, 0, 0, 0);
    ticks(3);
    applyStimulus(0, 1, 0, 0, 1, 0);
    tick();
    applyStimulus(0, 1, 0, 0, 0, 0);
    ticks(9);
    applyStimulus(0, 1, 0, 1, 0, 0);
    ticks(2);
    applyStimulus(0, 1, 0, 1, 1, 0);
    act_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.seq_active !== 1'b0) act_cnt++;
    end
    checkOne("masked_irq_active_cycles", 32'(act_cnt), 32'd0);

    // 3) BRK hijacked by an NMI edge arriving during the push cycles.
    $display("[TB] brk hijack");
    applyStimulus(0, 1, 1, 0, 0, 0);
    ticks(3);
    applyStimulus(0, 1, 1, 0, 1, 1);
    tick();
    applyStimulus(0, 0, 1, 0, 0, 0);
    ticks(9);
    applyStimulus(0, 1, 1, 0, 0, 0);
    ticks(3);

    // 4) NMI and IRQ at the same boundary: NMI first, IRQ eight cycles later.
    $display("[TB] nmi vs irq");
    applyStimulus(0, 0, 0, 0, 0, 0);
    ticks(4);
    applyStimulus(0, 0, 0, 0, 1, 0);
    first_t1 = -1; second_t1 = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.step[0] === 1'b1) begin
        if (first_t1 < 0) first_t1 = cyc;
        else if (second_t1 < 0) second_t1 = cyc;
      end
    end
    checkOne("back_to_back_spacing", 32'(second_t1 - first_t1), 32'd8);
    applyStimulus(0, 1, 1, 0, 0, 0);
    ticks(10);

    // 5) Reset during T3 of an IRQ entry aborts it and replays a reset entry.
    $display("[TB] reset abort");
    applyStimulus(0, 1, 0, 0, 0, 0);
    ticks(3);
    applyStimulus(0, 1, 0, 0, 1, 0);
    tick();
    applyStimulus(0, 1, 0, 0, 0, 0);
    guard = 0;
    while (m_pos != 3 && guard < 10) begin
      tick();
      guard++;
    end
    applyStimulus(1, 1, 0, 0, 0, 0);
    tick();
    checkOne("abort_step", 32'(bus.step), 32'd0);
    applyStimulus(0, 1, 1, 0, 0, 0);
    ticks(10);

    // 6) Second NMI edge landing in T5 yields exactly one more NMI entry.
    $display("[TB] nmi re-arm");
    applyStimulus(0, 1, 1, 1, 0, 0);
    ticks(3);
    t1_cnt = 0;
    applyStimulus(0, 0, 1, 1, 1, 0);
    guard = 0;
    while (m_pos != 1 && guard < 10) begin
      tick();
      guard++;
    end
    applyStimulus(0, 1, 1, 1, 1, 0);
    guard = 0;
    while (m_pos != 3 && guard < 10) begin
      tick();
      guard++;
    end
    applyStimulus(0, 0, 1, 1, 1, 0);
    ticks(30);
    checkOne("nmi_entries", 32'(t1_cnt), 32'd2);
    applyStimulus(0, 1, 1, 1, 0, 0);
    ticks(10);

    // 7) Random traffic against the model.
    $display("[TB] random traffic");
    nmi_v = 1'b1;
    irq_v = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(5) == 0) nmi_v = ~nmi_v;
      if ($urandom_range(4) == 0) irq_v = ~irq_v;
      applyStimulus(bit'($urandom_range(49) == 0), nmi_v, irq_v, bit'($urandom_range(1)),
                    bit'($urandom_range(2) == 0), bit'($urandom_range(3) == 0));
      tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
